// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared state type and 7-segment constants for io_responder
package io_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2
    } io_state_t;

    // Active-low segments, bit order gfedcba
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam int MAX_DEC = 9999;

    function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
        return (bcd <= 4'd9) ? SEG_DIGIT[bcd] : SEG_DASH;
    endfunction

endpackage

// File: rtl/io_responder_if.sv
// rtl/io_responder_if.sv - CPU-side inop/outop/await request bus
interface io_responder_if;
    logic        clk_state;
    logic        inop;
    logic        outop;
    logic [31:0] dm;
    logic [31:0] du;
    logic        await;

    modport master (output clk_state, inop, outop, dm, input du, await);
    modport slave  (input clk_state, inop, outop, dm, output du, await);
endinterface

// File: rtl/io_bcd_conv.sv
// rtl/io_bcd_conv.sv - sequential double-dabble binary to 4-digit BCD converter
module io_bcd_conv #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [W-1:0] value,
    output logic         busy,
    output logic         done,
    output logic [15:0]  bcd
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  shreg;
    logic [15:0]   acc;
    logic [15:0]   adj;
    logic [CW-1:0] cnt;

    always_comb begin
        adj = acc;
        for (int d = 0; d < 4; d++) begin
            if (acc[d*4 +: 4] >= 4'd5) begin
                adj[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
            end
        end
    end

    // A start while busy simply reloads, abandoning the old value
    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
            bcd   <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                shreg <= value;
                acc   <= '0;
                cnt   <= CW'(W);
                busy  <= 1'b1;
            end else if (busy) begin
                {acc, shreg} <= {adj[14:0], shreg, 1'b0};
                cnt          <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    bcd  <= {adj[14:0], shreg[W-1]};
                end
            end
        end
    end
endmodule

// File: rtl/io_responder.sv
// rtl/io_responder.sv - device side of the CPU inop/outop/await protocol
// Optional: define IO_ECHO_EN to also show a captured input value on the display.
module io_responder
    import io_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          SW_W            = 14
) (
    input  logic            clk,
    input  logic            bt_reset,
    io_responder_if.slave   cpu,
    input  logic            bt_n,
    input  logic [SW_W-1:0] in,
    output logic [27:0]     display
);
    logic [1:0]      bt_sync;
    logic [1:0]      cs_sync;
    logic            cs_prev;
    logic            step;
    logic            bt_level;
    logic [15:0]     deb_cnt;
    logic            press;
    io_state_t       state;
    logic            served;
    logic            conv_start;
    logic [SW_W-1:0] conv_value;
    logic [SW_W-1:0] conv_latched;
    logic            conv_busy;
    logic            conv_done;
    logic [15:0]     conv_bcd;
    logic            unused_sig;

    assign unused_sig = &{1'b0, conv_busy, cpu.dm[31:SW_W]};

    always_ff @(posedge clk) begin
        if (!bt_reset) begin
            bt_sync <= 2'b11;
            cs_sync <= 2'b00;
            cs_prev <= 1'b0;
        end else begin
            bt_sync <= {bt_sync[0], bt_n};
            cs_sync <= {cs_sync[0], cpu.clk_state};
            cs_prev <= cs_sync[1];
        end
    end

    assign step = cs_sync[1] & ~cs_prev;

    // bt_level: 1 = released; press pulses once when a debounced press is accepted
    always_ff @(posedge clk) begin
        if (!bt_reset) begin
            deb_cnt  <= '0;
            bt_level <= 1'b1;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (bt_sync[1] == bt_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt + 16'd1 >= DEBOUNCE_CYCLES) begin
                deb_cnt  <= '0;
                bt_level <= bt_sync[1];
                press    <= ~bt_sync[1];
            end else begin
                deb_cnt <= deb_cnt + 16'd1;
            end
        end
    end

    assign cpu.await = (state == IDLE && cpu.inop && !served)
                     || (state == WAIT_PRESS)
                     || (state == WAIT_RELEASE);

    // served stays set until the CPU advances, so a held request is serviced once
    always_ff @(posedge clk) begin
        if (!bt_reset) begin
            state  <= IDLE;
            served <= 1'b0;
            cpu.du <= '0;
        end else begin
            if (step) begin
                served <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cpu.inop && !served) begin
                        state <= WAIT_PRESS;
                    end else if (cpu.outop && !served) begin
                        served <= 1'b1;
                    end
                end
                WAIT_PRESS: begin
                    if (press) begin
                        cpu.du <= 32'(in);
                        state  <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (bt_level) begin
                        served <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        conv_start = 1'b0;
        conv_value = cpu.dm[SW_W-1:0];
        if (state == IDLE && !cpu.inop && cpu.outop && !served) begin
            conv_start = 1'b1;
        end
`ifdef IO_ECHO_EN
        if (state == WAIT_PRESS && press) begin
            conv_start = 1'b1;
            conv_value = in;
        end
`endif
    end

    io_bcd_conv #(.W(SW_W)) u_conv (
        .clk    (clk),
        .resetn (bt_reset),
        .start  (conv_start),
        .value  (conv_value),
        .busy   (conv_busy),
        .done   (conv_done),
        .bcd    (conv_bcd)
    );

    // All four digits change together when a conversion completes
    always_ff @(posedge clk) begin
        if (!bt_reset) begin
            conv_latched <= '0;
            display      <= {4{SEG_DIGIT[0]}};
        end else begin
            if (conv_start) begin
                conv_latched <= conv_value;
            end
            if (conv_done) begin
                if (32'(conv_latched) > 32'(MAX_DEC)) begin
                    display <= {4{SEG_DASH}};
                end else begin
                    display <= {seg_encode(conv_bcd[15:12]), seg_encode(conv_bcd[11:8]),
                                seg_encode(conv_bcd[7:4]),   seg_encode(conv_bcd[3:0])};
                end
            end
        end
    end
endmodule

// File: tb/tb_io_responder.sv
// tb/tb_io_responder.sv - randomized self-checking bench for io_responder
module tb_io_responder;
    localparam logic [15:0] DEB  = 16'd16;
    localparam int          DEBI = 16;
    localparam int          W    = 14;

    logic         clk = 1'b0;
    logic         bt_reset = 1'b0;
    logic         bt_n = 1'b1;
    logic [W-1:0] in_sw = '0;
    logic [27:0]  display;

    io_responder_if cpu_bus();

    io_responder #(.DEBOUNCE_CYCLES(DEB), .SW_W(W)) dut (
        .clk      (clk),
        .bt_reset (bt_reset),
        .cpu      (cpu_bus),
        .bt_n     (bt_n),
        .in       (in_sw),
        .display  (display)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [27:0] exp_disp = '0;
    logic [27:0] new_disp = '0;
    bit          disp_pend = 1'b0;
    int          disp_dl = 0;
    logic [31:0] exp_du = '0;
    logic [31:0] new_du = '0;
    bit          du_pend = 1'b0;
    int          du_dl = 0;
    int          exp_await = 0;
    bit          chk_en = 1'b0;
    logic [27:0] disp_before;
    logic [31:0] val;

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [27:0] seg_expect(input logic [31:0] v);
        int n;
        n = int'(v % 32'd16384);
        if (n > 9999) return {4{7'b0111111}};
        return {seg7(n / 1000), seg7((n / 100) % 10), seg7((n / 10) % 10), seg7(n % 10)};
    endfunction

    function automatic logic [31:0] rand_dm();
        case ($urandom_range(0, 4))
            0: return 32'd9999;
            1: return 32'd10000;
            2: return 32'($urandom_range(0, 9999));
            3: return $urandom;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_await != 2) check("await", 32'(cpu_bus.await), 32'(exp_await));
            if (disp_pend && display == new_disp) begin
                exp_disp  = new_disp;
                disp_pend = 1'b0;
            end
            if (disp_pend) begin
                disp_dl--;
                if (disp_dl <= 0) begin
                    check("display_latency", 32'(display), 32'(new_disp));
                    exp_disp  = new_disp;
                    disp_pend = 1'b0;
                end else begin
                    check("display_atomic", 32'(display), 32'(exp_disp));
                end
            end else begin
                check("display", 32'(display), 32'(exp_disp));
            end
            if (du_pend && cpu_bus.du == new_du) begin
                exp_du  = new_du;
                du_pend = 1'b0;
            end
            if (du_pend) begin
                du_dl--;
                if (du_dl <= 0) begin
                    check("du_latency", cpu_bus.du, new_du);
                    exp_du  = new_du;
                    du_pend = 1'b0;
                end else begin
                    check("du_hold", cpu_bus.du, exp_du);
                end
            end else begin
                check("du", cpu_bus.du, exp_du);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_display(input logic [31:0] v, input int dl);
        new_disp  = seg_expect(v);
        disp_pend = 1'b1;
        disp_dl   = dl;
    endtask

    task automatic do_step();
        cpu_bus.inop  = 1'b0;
        cpu_bus.outop = 1'b0;
        exp_await     = 0;
        tick(1);
        cpu_bus.clk_state = 1'b1;
        tick(4);
        cpu_bus.clk_state = 1'b0;
        tick(2);
    endtask

    task automatic raise_inop(input logic [W-1:0] v);
        in_sw        = v;
        cpu_bus.inop = 1'b1;
        exp_await    = 1;
        #1;
        check("await_same_cycle", 32'(cpu_bus.await), 32'd1);
        tick(3);
    endtask

    task automatic press_release();
        bt_n    = 1'b0;
        new_du  = 32'(in_sw);
        du_pend = 1'b1;
        du_dl   = DEBI + 4;
`ifdef IO_ECHO_EN
        expect_display(32'(in_sw), DEBI + W + 5);
`endif
        tick(DEBI + 5);
        check("du_capture", cpu_bus.du, 32'(in_sw));
        check("await_while_held", 32'(cpu_bus.await), 32'd1);
        bt_n      = 1'b1;
        exp_await = 2;
        tick(DEBI + 6);
        exp_await = 0;
        check("await_after_release", 32'(cpu_bus.await), 32'd0);
    endtask

    task automatic output_op(input logic [31:0] v);
        cpu_bus.dm    = v;
        cpu_bus.outop = 1'b1;
        exp_await     = 0;
        expect_display(v, W + 3);
        tick(W + 4);
        check("display_out", 32'(display), 32'(seg_expect(v)));
        do_step();
    endtask

    initial begin
        cpu_bus.clk_state = 1'b0;
        cpu_bus.inop      = 1'b0;
        cpu_bus.outop     = 1'b0;
        cpu_bus.dm        = '0;

        check("model_507",   32'(seg_expect(32'd507)),   32'h804A078);
        check("model_0",     32'(seg_expect(32'd0)),     32'h8102040);
        check("model_12000", 32'(seg_expect(32'd12000)), 32'h7EFDFBF);
        check("model_42",    32'(seg_expect(32'd42)),    32'h8100CA4);

        tick(2);
        check("reset_await",   32'(cpu_bus.await), 32'd0);
        check("reset_du",      cpu_bus.du,         32'd0);
        check("reset_display", 32'(display),       32'h8102040);
        bt_reset = 1'b1;
        exp_disp = 28'h8102040;
        chk_en   = 1'b1;
        tick(2);

        // reset during a conversion must abandon it
        cpu_bus.dm    = 32'd1234;
        cpu_bus.outop = 1'b1;
        tick(5);
        chk_en        = 1'b0;
        cpu_bus.outop = 1'b0;
        bt_reset      = 1'b0;
        tick(2);
        bt_reset = 1'b1;
        chk_en   = 1'b1;
        tick(W + 8);

        // reset while waiting for a press
        raise_inop(14'd5);
        chk_en       = 1'b0;
        cpu_bus.inop = 1'b0;
        bt_reset     = 1'b0;
        tick(1);
        check("await_after_reset", 32'(cpu_bus.await), 32'd0);
        bt_reset  = 1'b1;
        exp_await = 0;
        tick(1);
        chk_en = 1'b1;
        tick(2);

        raise_inop(14'd1234);
        press_release();
        check("du_1234", cpu_bus.du, 32'd1234);
        tick(30);
        do_step();

        raise_inop(14'd777);
        repeat (4) begin
            bt_n = 1'b0;
            tick(10);
            bt_n = 1'b1;
            tick(10);
        end
        check("glitch_await", 32'(cpu_bus.await), 32'd1);
        press_release();
        do_step();

        disp_before = display;
        raise_inop(14'd42);
        press_release();
`ifdef IO_ECHO_EN
        check("echo_0042", 32'(display), 32'h8100CA4);
`else
        check("no_echo", 32'(display), 32'(disp_before));
`endif
        do_step();

        output_op(32'd507);
        check("display_507", 32'(display), 32'h804A078);
        output_op(32'd12000);
        check("display_dash", 32'(display), 32'h7EFDFBF);

        // held outop: one conversion per CPU step, using dm at that step
        cpu_bus.dm    = 32'd111;
        cpu_bus.outop = 1'b1;
        expect_display(32'd111, W + 3);
        tick(W + 4);
        for (int k = 0; k < 3; k++) begin
            cpu_bus.dm = 32'(222 + 111 * k);
            tick(20);
            cpu_bus.clk_state = 1'b1;
            expect_display(cpu_bus.dm, W + 7);
            tick(4);
            cpu_bus.clk_state = 1'b0;
            tick(W + 6);
            check("step_conv", 32'(display), 32'(seg_expect(32'(222 + 111 * k))));
        end
        do_step();

        disp_before   = display;
        cpu_bus.dm    = 32'd4321;
        cpu_bus.outop = 1'b1;
        raise_inop(14'd55);
        press_release();
`ifndef IO_ECHO_EN
        check("priority_display", 32'(display), 32'(disp_before));
`endif
        do_step();

        bt_n = 1'b0;
        tick(DEBI + 6);
        raise_inop(14'd99);
        tick(DEBI + 6);
        check("held_no_capture", cpu_bus.du, exp_du);
        bt_n = 1'b1;
        tick(DEBI + 6);
        check("held_await", 32'(cpu_bus.await), 32'd1);
        press_release();
        check("rearm_capture", cpu_bus.du, 32'd99);
        do_step();

        // restart: second outop arrives while the first is still converting
        cpu_bus.dm    = 32'd8888;
        cpu_bus.outop = 1'b1;
        tick(1);
        cpu_bus.outop     = 1'b0;
        cpu_bus.clk_state = 1'b1;
        tick(4);
        cpu_bus.clk_state = 1'b0;
        val           = 32'($urandom_range(0, 9999));
        cpu_bus.dm    = val;
        cpu_bus.outop = 1'b1;
        expect_display(val, W + 3);
        tick(W + 4);
        check("restart", 32'(display), 32'(seg_expect(val)));
        do_step();

        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                output_op(rand_dm());
            end else begin
                raise_inop(W'($urandom_range(0, 16383)));
                if ($urandom_range(0, 1) == 1) begin
                    bt_n = 1'b0;
                    tick($urandom_range(2, DEBI - 4));
                    bt_n = 1'b1;
                    tick(8);
                end
                press_release();
                do_step();
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
